// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, hazard/redirect controls
// and the IF/ID pipeline register outputs.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]  instr_addr;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   stall;
    logic                   flush;
    logic                   branch_taken;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic                   jump;
    logic [ADDR_WIDTH-1:0]  jump_target;
    logic                   if_id_valid;
    logic [INSTR_WIDTH-1:0] if_id_instr;
    logic [ADDR_WIDTH-1:0]  if_id_pc_plus4;
    logic [31:0]            fetch_count;

    // The fetch unit drives addresses and the IF/ID register
    modport master (
        output instr_addr,
        input  instr,
        input  stall,
        input  flush,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_target,
        output if_id_valid,
        output if_id_instr,
        output if_id_pc_plus4,
        output fetch_count
    );

    modport slave (
        input  instr_addr,
        output instr,
        output stall,
        output flush,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_target,
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_pc_plus4,
        input  fetch_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: word-aligned PC with jump/branch/stall priority
// and an IF/ID register that supports flush and stall.
module instr_fetch #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);
    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK    = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_WORD = RESET_PC & ALIGN_MASK;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic                   if_id_valid;
    logic [INSTR_WIDTH-1:0] if_id_instr;
    logic [ADDR_WIDTH-1:0]  if_id_pc_plus4;
    logic [31:0]            fetch_count;

    // Addition wraps naturally modulo 2^ADDR_WIDTH
    assign pc_plus4 = pc + ADDR_WIDTH'(4);

    always_comb begin
        pc_next = pc_plus4;
        if (bus.jump)
            pc_next = bus.jump_target & ALIGN_MASK;
        else if (bus.branch_taken)
            pc_next = bus.branch_target & ALIGN_MASK;
        else if (bus.stall)
            pc_next = pc;
    end

    // BOOT spends one edge after reset release so the first load sees RESET_PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_PC_WORD;
            if_id_valid    <= 1'b0;
            if_id_instr    <= '0;
            if_id_pc_plus4 <= '0;
            fetch_count    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    pc <= pc_next;
                    if (bus.flush) begin
                        if_id_valid    <= 1'b0;
                        if_id_instr    <= '0;
                        if_id_pc_plus4 <= '0;
                    end else if (!bus.stall) begin
                        if_id_valid    <= 1'b1;
                        if_id_instr    <= bus.instr;
                        if_id_pc_plus4 <= pc_plus4;
                        if (fetch_count != '1)
                            fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign bus.instr_addr     = pc;
    assign bus.if_id_valid    = if_id_valid;
    assign bus.if_id_instr    = if_id_instr;
    assign bus.if_id_pc_plus4 = if_id_pc_plus4;
    assign bus.fetch_count    = fetch_count;
endmodule
